// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: next-PC source encoding, FSM states, default width.
package pc_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_PCREL  = 2'd1,
        SEL_REGREL = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// The count saturates at DEPTH. Pop together with push replaces the top entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   top_idx;

    // ptr_q points at the next free slot; the top entry sits just below it.
    assign top_idx = ptr_q - PW'(1);

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push && pop && count_q != '0) begin
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (count_q != CW'(DEPTH))
                count_d = count_q + CW'(1);
        end else if (pop && count_q != '0) begin
            ptr_d   = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[top_idx];
    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with BOOT/RUN/TRAP sequencing and flush redirect.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int unsigned    RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap,
    output logic [1:0]      state,
    output logic            ras_hit
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    pc_sel_e         sel_e;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] regrel_sum;
    logic            misaligned;
    logic            ras_use;
    logic [XLEN-1:0] ras_top;

    assign sel_e      = pc_sel_e'(sel);
    assign pc_plus4   = pc_q + XLEN'(4);
    assign regrel_sum = rs1 + imm;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;
    logic          commit;
    logic          ras_push, ras_pop;
    logic [CW-1:0] ras_count;

    assign ras_use  = (state_q == ST_RUN) && (sel_e == SEL_REGREL) && is_ret && (ras_count != '0);
    assign commit   = (state_q == ST_RUN) && advance && !flush && !misaligned;
    assign ras_pop  = commit && ras_use;
    assign ras_push = commit && is_call && (sel_e == SEL_PCREL || sel_e == SEL_REGREL);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count)
    );
`else
    logic unused_ras_hints;
    assign unused_ras_hints = is_call | is_ret;
    assign ras_use          = 1'b0;
    assign ras_top          = '0;
`endif

    always_comb begin
        target     = pc_q;
        misaligned = 1'b0;
        case (sel_e)
            SEL_SEQ:    target = pc_plus4;
            SEL_PCREL: begin
                target     = pc_q + imm;
                misaligned = (target[1:0] != 2'b00);
            end
            SEL_REGREL: begin
                target     = ras_use ? ras_top : {regrel_sum[XLEN-1:1], 1'b0};
                misaligned = (target[1:0] != 2'b00);
            end
            default:    target = pc_q;
        endcase
    end

    // Flush outranks advance; a misaligned target leaves pc alone and goes to TRAP.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VECTOR;
            end
            ST_TRAP: begin
                state_d = ST_RUN;
                pc_d    = TRAP_VECTOR;
            end
            ST_RUN: begin
                if (flush)
                    pc_d = flush_target;
                else if (advance) begin
                    if (misaligned)
                        state_d = ST_TRAP;
                    else
                        pc_d = target;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign state   = state_q;
    assign trap    = (state_q == ST_TRAP);
    assign ras_hit = ras_use;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_sequencer;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [31:0] RV        = 32'h0;
    localparam logic [31:0] TV        = 32'h100;
`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        advance;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        is_call;
    logic        is_ret;
    logic        flush;
    logic [31:0] flush_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [1:0]  state;
    logic        ras_hit;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_pc;
    int          m_state;
    logic [31:0] m_ras[$];
    bit          m_known = 1'b0;

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .advance      (advance),
        .sel          (sel),
        .imm          (imm),
        .rs1          (rs1),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .flush        (flush),
        .flush_target (flush_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .trap         (trap),
        .state        (state),
        .ras_hit      (ras_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit r, input bit adv, input logic [1:0] s, input logic [31:0] im,
                         input logic [31:0] r1, input bit c, input bit rt, input bit fl,
                         input logic [31:0] ft);
        reset = r; advance = adv; sel = s; imm = im; rs1 = r1;
        is_call = c; is_ret = rt; flush = fl; flush_target = ft;
    endtask

    function automatic bit model_ras_hit();
        return RAS_EN && m_state == 1 && sel == 2'd2 && is_ret && m_ras.size() > 0;
    endfunction

    // Reference behaviour for one rising edge, from the current model state and inputs.
    task automatic model_step();
        logic [31:0] t;
        bit          mis;
        bit          use_ras;
        if (reset) begin
            m_pc = RV; m_state = 0; m_ras.delete();
            return;
        end
        case (m_state)
            0: begin m_state = 1; m_pc = RV; end
            2: begin m_state = 1; m_pc = TV; end
            default: begin
                if (flush) m_pc = flush_target;
                else if (advance) begin
                    use_ras = model_ras_hit();
                    mis = 1'b0;
                    case (sel)
                        2'd0: t = m_pc + 32'd4;
                        2'd1: begin t = m_pc + imm; mis = (t[1:0] != 2'b00); end
                        2'd2: begin
                            t = use_ras ? m_ras[$] : ((rs1 + imm) & ~32'h1);
                            mis = (t[1:0] != 2'b00);
                        end
                        default: t = m_pc;
                    endcase
                    if (mis) m_state = 2;
                    else begin
                        if (use_ras) void'(m_ras.pop_back());
                        if (RAS_EN && is_call && (sel == 2'd1 || sel == 2'd2)) begin
                            m_ras.push_back(m_pc + 32'd4);
                            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                        end
                        m_pc = t;
                    end
                end
            end
        endcase
    endtask

    task automatic tick();
        #1;
        if (m_known) begin
            check("pc_pre", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("state_pre", 32'(state), 32'(m_state));
            check("trap", 32'(trap), 32'(m_state == 2));
            check("ras_hit", 32'(ras_hit), 32'(model_ras_hit()));
        end
        model_step();
        m_known = 1'b1;
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("state", 32'(state), 32'(m_state));
    endtask

    initial begin
        logic [31:0] exp_ret [5];
        drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_pc", pc, 32'h0);

        // Boot cycle ignores advance, then three sequential steps.
        drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("boot_exit_state", 32'(state), 32'd1);
        check("boot_exit_pc", pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", pc, 32'(4 * i));
        end

        // Wrap-around arithmetic.
        drive(0, 1, 2'd0, 0, 0, 0, 0, 1, 32'h10);
        tick();
        drive(0, 1, 2'd1, -32'sh20, 0, 0, 0, 0, 0);
        tick();
        check("pcrel_neg", pc, 32'hFFFF_FFF0);
        drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("seq_after_neg", pc, 32'hFFFF_FFF4);
        drive(0, 1, 2'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("seq_wrap", pc, 32'h0);

        // REGREL bit-0 clear, then misaligned target with flush ignored in TRAP.
        drive(0, 1, 2'd2, 0, 32'h101, 0, 0, 0, 0);
        tick();
        check("regrel_clear_b0", pc, 32'h100);
        drive(0, 1, 2'd2, 0, 32'h102, 0, 0, 0, 0);
        tick();
        check("mis_state_trap", 32'(state), 32'd2);
        check("mis_pc_hold", pc, 32'h100);
        drive(0, 1, 2'd0, 0, 0, 0, 0, 1, 32'h40);
        tick();
        check("trap_exit_pc", pc, TV);
        check("trap_exit_state", 32'(state), 32'd1);

        // Flush overrides advance.
        drive(0, 1, 2'd1, 32'h8, 0, 0, 0, 1, 32'h40);
        tick();
        check("flush_pc", pc, 32'h40);

        // Call/return through the stack, then overflow past the depth.
        drive(0, 1, 2'd0, 0, 0, 0, 0, 1, 32'h20);
        tick();
        drive(0, 1, 2'd1, 32'h40, 0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 2'd2, 0, 32'h0, 0, 1, 0, 0);
        tick();
        check("ret_pc", pc, RAS_EN ? 32'h24 : 32'h0);
        drive(0, 1, 2'd0, 0, 0, 0, 0, 1, 32'h24);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'd1, 32'h100, 0, 1, 0, 0, 0);
            tick();
        end
        exp_ret = '{32'h428, 32'h328, 32'h228, 32'h128, 32'h800};
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'd2, 0, 32'h800, 0, 1, 0, 0);
            tick();
            check("ret_chain", pc, RAS_EN ? exp_ret[i] : 32'h800);
        end

        // Reset asserted inside the TRAP cycle, with a live stack entry.
        drive(0, 1, 2'd1, 32'h10, 0, 1, 0, 0, 0);
        tick();
        drive(0, 1, 2'd2, 0, 32'h2, 0, 0, 0, 0);
        tick();
        check("pre_reset_trap", 32'(state), 32'd2);
        drive(1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("trap_reset_state", 32'(state), 32'd0);
        check("trap_reset_pc", pc, RV);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 2'd2, 0, 32'h80, 0, 1, 0, 0);
        tick();
        check("ras_empty_after_reset", pc, 32'h80);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r_imm;
            logic [31:0] r_rs1;
            r_imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            r_rs1 = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_3FFD);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  r_imm, r_rs1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom & 32'hFFFF_FFFC);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
